// File: rtl/uart7n_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart7n_tx_arbiter_if
// Requester-side bus of the shared UART transmitter arbiter.
//   req_valid_i : per-requester byte-pending flag      (requester -> arbiter)
//   req_data_i  : per-requester byte, k at [8k+7:8k]   (requester -> arbiter)
//   req_ready_o : per-requester accept strobe          (arbiter -> requester)
//   req_done_o  : per-requester completion pulse       (arbiter -> requester)
// The slave modport is the arbiter view; master is the requester view.
// -----------------------------------------------------------------------------
interface uart7n_tx_arbiter_if #(
  parameter int p_num_req = 4
) ();

  logic [p_num_req-1:0]   req_valid_i;
  logic [8*p_num_req-1:0] req_data_i;
  logic [p_num_req-1:0]   req_ready_o;
  logic [p_num_req-1:0]   req_done_o;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    output req_ready_o,
    output req_done_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    input  req_ready_o,
    input  req_done_o
  );

endinterface

// File: rtl/uart7n_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart7n_tx_arbiter
// Round-robin arbiter that lets p_num_req requesters share one UART
// transmitter. A granted byte is loaded into data_tx_o, the transmitter is
// enabled, and the owner gets a one-cycle done pulse once the transmitter
// reports the byte as sent. A transmitter that never goes busy after launch
// is abandoned after p_start_timeout cycles and a sticky error is raised.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_n_i        : asynchronous active-low reset
//   req_if         : requester bus (valid/data in, ready/done out)
//   grant_id_o     : index of the requester owning the transmitter
//   enable_tx_o    : transmitter enable
//   data_tx_o      : transmitter data register
//   tx_busy_i      : transmitter busy flag
//   tx_data_sent_i : transmitter "can be reloaded" flag
//   active_o       : FSM is not idle
//   timeout_err_o  : sticky launch-timeout flag (cleared only by reset)
// -----------------------------------------------------------------------------
module uart7n_tx_arbiter #(
  parameter int p_num_req       = 4,
  parameter int p_start_timeout = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  uart7n_tx_arbiter_if.slave           req_if,
  output logic [$clog2(p_num_req)-1:0] grant_id_o,
  output logic                         enable_tx_o,
  output logic [7:0]                   data_tx_o,
  input  logic                         tx_busy_i,
  input  logic                         tx_data_sent_i,
  output logic                         active_o,
  output logic                         timeout_err_o
);

  localparam int                   lp_id_w     = $clog2(p_num_req);
  localparam logic [lp_id_w-1:0]   lp_last_rst = lp_id_w'(p_num_req - 1);
  localparam logic [7:0]           lp_cnt_last = 8'(p_start_timeout - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t               state_q;
  logic                 enable_q;
  logic                 err_q;
  logic [p_num_req-1:0] done_q;
  logic [7:0]           data_q;
  logic [lp_id_w-1:0]   grant_q;
  logic [lp_id_w-1:0]   last_q;
  logic [7:0]           cnt_q;

  logic [lp_id_w:0]     pick_s;
  logic                 win_found_s;
  logic [lp_id_w-1:0]   win_id_s;
  logic [p_num_req-1:0] ready_s;
  logic                 hs_s;

  // Round-robin pick: first valid requester after 'last', wrapping modulo
  // p_num_req. Returns {found, index}.
  function automatic logic [lp_id_w:0] f_rr_pick(
    input logic [p_num_req-1:0] valid,
    input logic [lp_id_w-1:0]   last
  );
    logic               found;
    logic [lp_id_w-1:0] id;
    int                 cand;
    found = 1'b0;
    id    = '0;
    for (int i = 1; i <= p_num_req; i++) begin
      cand = (int'(last) + i) % p_num_req;
      if (!found && valid[cand]) begin
        found = 1'b1;
        id    = cand[lp_id_w-1:0];
      end else begin
        found = found;
      end
    end
    return {found, id};
  endfunction

  assign pick_s      = f_rr_pick(req_if.req_valid_i, last_q);
  assign win_found_s = pick_s[lp_id_w];
  assign win_id_s    = pick_s[lp_id_w-1:0];

  // Accept strobe: only the winner, only in IDLE, and forced low while reset
  // is asserted so a held valid cannot produce a ready during reset.
  always_comb begin
    ready_s = '0;
    if (rst_n_i && (state_q == ST_IDLE) && win_found_s) begin
      ready_s[win_id_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign hs_s = |ready_s;

  // Arbitration / launch / completion FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= '0;
      data_q   <= 8'h00;
      grant_q  <= '0;
      last_q   <= lp_last_rst;
      cnt_q    <= 8'd0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // tx_busy_i / tx_data_sent_i are deliberately not looked at here.
          if (hs_s) begin
            data_q   <= req_if.req_data_i[{win_id_s, 3'b000} +: 8];
            grant_q  <= win_id_s;
            last_q   <= win_id_s;
            enable_q <= 1'b1;
            cnt_q    <= 8'd0;
            state_q  <= ST_LAUNCH;
          end else begin
            cnt_q <= 8'd0;
          end
        end
        ST_LAUNCH: begin
          if (tx_busy_i) begin
            state_q <= ST_WAIT;
          end else if (cnt_q == lp_cnt_last) begin
            // Transmitter never started: give up without a done pulse.
            enable_q <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WAIT: begin
          if (!tx_busy_i && tx_data_sent_i) begin
            done_q[grant_q] <= 1'b1;
            enable_q        <= 1'b0;
            state_q         <= ST_IDLE;
          end else begin
            enable_q <= 1'b1;
          end
        end
        default: begin
          enable_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready_o = ready_s;
  assign req_if.req_done_o  = done_q;
  assign grant_id_o         = grant_q;
  assign enable_tx_o        = enable_q;
  assign data_tx_o          = data_q;
  assign active_o           = (state_q != ST_IDLE);
  assign timeout_err_o      = err_q;

endmodule

// File: doc/uart7n_tx_arbiter.md
UART7N_TX_ARBITER -- requirements
Module: uart7n_tx_arbiter

Interface
REQ-001 Parameter p_num_req, default 4, SHALL set the number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 Parameter p_start_timeout, default 16, SHALL set the clock cycles allowed from launch until tx_busy_i is seen (legal 2..255).
REQ-003 clk_i  input  1  SHALL be the single clock; every flop SHALL be clocked on its rising edge.
REQ-004 rst_n_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid_i  input  p_num_req  SHALL carry a per-requester byte-pending flag.
REQ-006 req_data_i  input  8*p_num_req  SHALL carry the per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 req_ready_o  output  p_num_req  SHALL be the per-requester accept strobe.
REQ-008 req_done_o  output  p_num_req  SHALL be the per-requester one-cycle completion pulse.
REQ-009 grant_id_o  output  clog2(p_num_req)  SHALL give the index of the requester currently owning the transmitter.
REQ-010 enable_tx_o  output  1  SHALL drive the transmitter enable.
REQ-011 data_tx_o  output  8  SHALL drive the transmitter data register.
REQ-012 tx_busy_i  input  1  SHALL be the transmitter busy flag.
REQ-013 tx_data_sent_i  input  1  SHALL be the transmitter "can be reloaded" flag.
REQ-014 active_o  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-015 timeout_err_o  output  1  SHALL be a sticky flag set on a launch timeout.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH and WAIT.
REQ-017 IDLE behaviour:
- req_ready_o SHALL be combinationally high for the round-robin winner only, and only when req_valid_i of that winner is high.
- A handshake is valid&ready in the same cycle.
- On a handshake, data_tx_o SHALL register the winner's byte, grant_id_o SHALL register the winner, and the FSM SHALL go to LAUNCH.
REQ-018 Round-robin order:
- The search SHALL start at last_grant+1 and wrap modulo p_num_req.
- last_grant SHALL update on each handshake.
- Reset value of last_grant SHALL be p_num_req-1, so requester 0 wins first.
REQ-019 A requester SHALL hold req_valid_i and req_data_i stable until it sees req_ready_o; valids dropped before a handshake SHALL be ignored without error.
REQ-020 LAUNCH behaviour:
- enable_tx_o SHALL be high and a cycle counter SHALL increment from 0.
- On tx_busy_i=1, the FSM SHALL go to WAIT.
- If the counter reaches p_start_timeout-1 without tx_busy_i, the FSM SHALL go to IDLE, set timeout_err_o, and emit no req_done_o.
REQ-021 WAIT behaviour:
- enable_tx_o SHALL stay high.
- When tx_busy_i=0 and tx_data_sent_i=1 in the same cycle, the FSM SHALL pulse req_done_o[grant_id_o] for exactly one cycle, drop enable_tx_o and go to IDLE.
REQ-022 data_tx_o and grant_id_o SHALL stay constant from the handshake until the FSM re-enters IDLE.
REQ-023 At most one bit of req_ready_o and at most one bit of req_done_o SHALL be high in any cycle; req_ready_o SHALL be all zero outside IDLE.
REQ-024 A new handshake SHALL be possible in the first IDLE cycle after completion, giving a minimum of 3 cycles between consecutive accepts.
REQ-025 timeout_err_o SHALL clear only on reset.
REQ-026 tx_busy_i and tx_data_sent_i SHALL be ignored in IDLE.

Reset
REQ-027 While rst_n_i=0, independent of clk_i:
- State SHALL be IDLE.
- enable_tx_o, active_o, timeout_err_o, req_ready_o and req_done_o SHALL be 0.
- data_tx_o SHALL be 8'h00, grant_id_o SHALL be 0, the counter SHALL be 0 and last_grant SHALL be p_num_req-1.
REQ-028 Reset asserted in LAUNCH or WAIT SHALL abort the transfer with no req_done_o pulse; the first post-reset grant SHALL again start at requester 0.

Verification
REQ-029 Single request: req_valid_i=4'b0100 with byte 8'hA5; model holds busy 5 cycles -> ready[2] pulses, data_tx_o=8'hA5, grant_id_o=2, done[2] exactly once.
REQ-030 Fairness: all four valid continuously, each with a distinct byte -> grant order 0,1,2,3,0 and data_tx_o matches each owner's byte.
REQ-031 Timeout: tx_busy_i stuck at 0 -> enable_tx_o high for 16 cycles, timeout_err_o=1, no done pulse, next requester served.
REQ-032 Mid-transfer reset: rst_n_i low during WAIT of grant 1 -> all outputs at reset values asynchronously, no done[1], next grant goes to requester 0.
REQ-033 Back-to-back: requester 3 valid continuously -> accepts spaced exactly 3 cycles when the model completes immediately; one-hot ready/done assertions hold throughout.
